// File: rtl/tcp_session_if.sv
// Segment, application and delivery channels of the TCP session engine.
// The session engine takes the slave view; its environment takes the master view.
interface tcp_session_if #(
    parameter int PAYLOAD_LEN = 262,
    parameter int TCPH_LEN    = 20
);
    localparam int SEG_W = (PAYLOAD_LEN + TCPH_LEN) * 8;
    localparam int PL_W  = PAYLOAD_LEN * 8;

    logic              app_valid;
    logic              app_ready;
    logic [PL_W-1:0]   app_payload;
    logic [15:0]       app_len;

    logic              rx_valid;
    logic              rx_ready;
    logic [SEG_W-1:0]  rx_seg;
    logic [15:0]       rx_len;

    logic              seg_valid;
    logic              seg_ready;
    logic [SEG_W-1:0]  seg_data;

    logic              rx_pl_valid;
    logic [PL_W-1:0]   rx_pl_data;

    modport master (
        output app_valid, app_payload, app_len,
        output rx_valid, rx_seg, rx_len,
        output seg_ready,
        input  app_ready, rx_ready, seg_valid, seg_data, rx_pl_valid, rx_pl_data
    );

    modport slave (
        input  app_valid, app_payload, app_len,
        input  rx_valid, rx_seg, rx_len,
        input  seg_ready,
        output app_ready, rx_ready, seg_valid, seg_data, rx_pl_valid, rx_pl_data
    );
endinterface

// File: rtl/tcp_session.sv
// Client-side TCP session engine: open, data with ACK tracking, retransmit on
// timeout and close, with one outbound segment register shared by all paths.
module tcp_session #(
    parameter int          PAYLOAD_LEN = 262,
    parameter int          TCPH_LEN    = 20,
    parameter logic [15:0] SRC_PORT    = 16'd1024,
    parameter logic [15:0] DST_PORT    = 16'd9000,
    parameter logic [15:0] WINDOW      = 16'd302,
    parameter logic [31:0] ISN         = 32'h0000_1000,
    parameter int          RTO_CYCLES  = 1000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        open_req,
    input  logic        close_req,
    output logic [2:0]  state,
    output logic        conn_err,
    tcp_session_if.slave bus
);
    localparam int SEG_W = (PAYLOAD_LEN + TCPH_LEN) * 8;
    localparam int PL_W  = PAYLOAD_LEN * 8;
    localparam int HDR_W = TCPH_LEN * 8;
    localparam int RTO_W = $clog2(RTO_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    // Timer fires while holding RTO_CYCLES-2 so the resend appears RTO_CYCLES after the handshake.
    localparam logic [RTO_W-1:0] RTO_LAST = RTO_W'(RTO_CYCLES - 2);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [15:0]      PL_MAX   = 16'(PAYLOAD_LEN);

    localparam logic [5:0] FL_SYN     = 6'b000010;
    localparam logic [5:0] FL_ACK     = 6'b010000;
    localparam logic [5:0] FL_PSH_ACK = 6'b011000;
    localparam logic [5:0] FL_FIN_ACK = 6'b010001;

    typedef enum logic [2:0] {
        S_CLOSED   = 3'd0,
        S_SYN_SENT = 3'd1,
        S_ESTAB    = 3'd2,
        S_ACK_WAIT = 3'd3,
        S_FIN_WAIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         snd_nxt_q, snd_nxt_d;
    logic [31:0]         rcv_nxt_q, rcv_nxt_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic [RTO_W-1:0]    rto_q, rto_d;
    logic                armed_q, armed_d;
    logic                seg_valid_q, seg_valid_d;
    logic                seg_ctl_q, seg_ctl_d;
    logic [SEG_W-1:0]    seg_data_q, seg_data_d;
    logic [SEG_W-1:0]    stored_q, stored_d;
    logic                pl_valid_q, pl_valid_d;
    logic [PL_W-1:0]     pl_data_q, pl_data_d;
    logic                err_q, err_d;

    function automatic logic [SEG_W-1:0] build_seg(
        input logic [31:0]     seq,
        input logic [31:0]     ack,
        input logic [5:0]      flags,
        input logic [PL_W-1:0] pl
    );
        logic [SEG_W-1:0] s;
        s                 = '0;
        s[15:0]           = SRC_PORT;
        s[31:16]          = DST_PORT;
        s[63:32]          = seq;
        s[95:64]          = ack;
        s[99:96]          = 4'(TCPH_LEN >> 2);
        s[111:106]        = flags;
        s[127:112]        = WINDOW;
        s[HDR_W +: PL_W]  = pl;
        return s;
    endfunction

    // Inbound segment fields
    logic [31:0] rx_seq, rx_ack;
    logic [5:0]  rx_flags;
    logic        rx_fin, rx_syn, rx_rst, rx_psh, rx_ackf;
    logic        unused_rx_fields;

    assign rx_seq   = bus.rx_seg[63:32];
    assign rx_ack   = bus.rx_seg[95:64];
    assign rx_flags = bus.rx_seg[111:106];
    assign rx_fin   = rx_flags[0];
    assign rx_syn   = rx_flags[1];
    assign rx_rst   = rx_flags[2];
    assign rx_psh   = rx_flags[3];
    assign rx_ackf  = rx_flags[4];
    assign unused_rx_fields = ^{bus.rx_seg[31:0], bus.rx_seg[105:96],
                                bus.rx_seg[159:112], rx_flags[5]};

    // Payload bytes beyond the (saturated) length are forced to zero.
    logic [15:0]     app_len_sat, rx_len_sat;
    logic [PL_W-1:0] app_pl_masked, rx_pl_masked;

    assign app_len_sat = (bus.app_len > PL_MAX) ? PL_MAX : bus.app_len;
    assign rx_len_sat  = (bus.rx_len  > PL_MAX) ? PL_MAX : bus.rx_len;

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_mask
            assign app_pl_masked[gi*8 +: 8] = (16'(gi) < app_len_sat) ?
                                              bus.app_payload[gi*8 +: 8] : 8'h00;
            assign rx_pl_masked[gi*8 +: 8]  = (16'(gi) < rx_len_sat) ?
                                              bus.rx_seg[HDR_W + gi*8 +: 8] : 8'h00;
        end
    endgenerate

    logic rx_hs, app_hs, seg_hs, tmr_run, timeout, rx_data;

    assign rx_hs   = bus.rx_valid && !seg_valid_q;
    assign app_hs  = bus.app_valid && (state_q == S_ESTAB) && !seg_valid_q;
    assign seg_hs  = seg_valid_q && bus.seg_ready;
    assign tmr_run = armed_q && ((state_q == S_SYN_SENT) || (state_q == S_ACK_WAIT) ||
                                 (state_q == S_FIN_WAIT));
    assign timeout = tmr_run && (rto_q == RTO_LAST) && !seg_valid_q;
    assign rx_data = rx_hs && !rx_rst && rx_psh &&
                     (((state_q == S_ESTAB) && !rx_fin) || (state_q == S_ACK_WAIT));

    logic             load, load_ctl, rx_used;
    logic [SEG_W-1:0] load_seg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLOSED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath decisions, highest priority first
    always_comb begin
        state_d     = state_q;
        snd_nxt_d   = snd_nxt_q;
        rcv_nxt_d   = rcv_nxt_q;
        retry_d     = retry_q;
        rto_d       = rto_q;
        armed_d     = armed_q;
        seg_valid_d = seg_valid_q && !seg_hs;
        seg_ctl_d   = seg_ctl_q;
        seg_data_d  = seg_data_q;
        stored_d    = stored_q;
        pl_valid_d  = 1'b0;
        pl_data_d   = pl_data_q;
        err_d       = 1'b0;
        load        = 1'b0;
        load_ctl    = 1'b0;
        load_seg    = '0;
        rx_used     = 1'b0;

        if (seg_hs && seg_ctl_q) begin
            armed_d = 1'b1;
            rto_d   = '0;
        end else if (tmr_run && (rto_q != RTO_LAST)) begin
            rto_d = rto_q + RTO_W'(1);
        end

        if (rx_hs && (state_q != S_CLOSED)) begin
            if (rx_rst) begin
                rx_used = 1'b1;
                state_d = S_CLOSED;
                err_d   = 1'b1;
                armed_d = 1'b0;
            end else begin
                case (state_q)
                    S_SYN_SENT: begin
                        if (rx_syn && rx_ackf && (rx_ack == snd_nxt_q)) begin
                            rx_used   = 1'b1;
                            rcv_nxt_d = rx_seq + 32'd1;
                            load      = 1'b1;
                            load_seg  = build_seg(snd_nxt_q, rx_seq + 32'd1, FL_ACK, '0);
                            state_d   = S_ESTAB;
                            armed_d   = 1'b0;
                            retry_d   = '0;
                        end
                    end
                    S_ESTAB: begin
                        if (rx_fin) begin
                            rx_used   = 1'b1;
                            rcv_nxt_d = rcv_nxt_q + 32'd1;
                            load      = 1'b1;
                            load_seg  = build_seg(snd_nxt_q, rcv_nxt_q + 32'd1, FL_ACK, '0);
                            state_d   = S_CLOSED;
                        end
                    end
                    S_ACK_WAIT: begin
                        if (rx_ackf && (rx_ack == snd_nxt_q)) begin
                            rx_used = 1'b1;
                            state_d = S_ESTAB;
                            retry_d = '0;
                            armed_d = 1'b0;
                            rto_d   = '0;
                        end
                    end
                    S_FIN_WAIT: begin
                        if (rx_ackf && (rx_ack == snd_nxt_q)) begin
                            rx_used = 1'b1;
                            state_d = S_CLOSED;
                            armed_d = 1'b0;
                            if (rx_fin) begin
                                rcv_nxt_d = rcv_nxt_q + 32'd1;
                                load      = 1'b1;
                                load_seg  = build_seg(snd_nxt_q, rcv_nxt_q + 32'd1, FL_ACK, '0);
                            end
                        end
                    end
                    default: ;
                endcase

                // Out-of-order data is dropped but still answered with a duplicate ACK.
                if (rx_data) begin
                    rx_used = 1'b1;
                    load    = 1'b1;
                    if (rx_seq == rcv_nxt_q) begin
                        pl_valid_d = 1'b1;
                        pl_data_d  = rx_pl_masked;
                        rcv_nxt_d  = rcv_nxt_q + {16'd0, bus.rx_len};
                        load_seg   = build_seg(snd_nxt_q, rcv_nxt_q + {16'd0, bus.rx_len},
                                               FL_ACK, '0);
                    end else begin
                        load_seg   = build_seg(snd_nxt_q, rcv_nxt_q, FL_ACK, '0);
                    end
                end
            end
        end

        if (!rx_used) begin
            if (timeout) begin
                if (retry_q == RTY_MAX) begin
                    state_d = S_CLOSED;
                    err_d   = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    retry_d  = retry_q + RTY_W'(1);
                    load     = 1'b1;
                    load_ctl = 1'b1;
                    load_seg = stored_q;
                end
            end else if (close_req && (state_q == S_ESTAB) && !seg_valid_q) begin
                load      = 1'b1;
                load_ctl  = 1'b1;
                load_seg  = build_seg(snd_nxt_q, rcv_nxt_q, FL_FIN_ACK, '0);
                snd_nxt_d = snd_nxt_q + 32'd1;
                retry_d   = '0;
                state_d   = S_FIN_WAIT;
            end else if (app_hs) begin
                load      = 1'b1;
                load_ctl  = 1'b1;
                load_seg  = build_seg(snd_nxt_q, rcv_nxt_q, FL_PSH_ACK, app_pl_masked);
                snd_nxt_d = snd_nxt_q + {16'd0, app_len_sat};
                retry_d   = '0;
                state_d   = S_ACK_WAIT;
            end else if (open_req && (state_q == S_CLOSED) && !seg_valid_q) begin
                load      = 1'b1;
                load_ctl  = 1'b1;
                load_seg  = build_seg(ISN, 32'd0, FL_SYN, '0);
                snd_nxt_d = ISN + 32'd1;
                retry_d   = '0;
                state_d   = S_SYN_SENT;
            end
        end

        // Loading a retransmittable segment keeps a copy and holds the timer until it is taken.
        if (load) begin
            seg_valid_d = 1'b1;
            seg_data_d  = load_seg;
            seg_ctl_d   = load_ctl;
            if (load_ctl) begin
                stored_d = load_seg;
                armed_d  = 1'b0;
                rto_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_nxt_q   <= ISN;
            rcv_nxt_q   <= '0;
            retry_q     <= '0;
            rto_q       <= '0;
            armed_q     <= 1'b0;
            seg_valid_q <= 1'b0;
            seg_ctl_q   <= 1'b0;
            seg_data_q  <= '0;
            stored_q    <= '0;
            pl_valid_q  <= 1'b0;
            pl_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            snd_nxt_q   <= snd_nxt_d;
            rcv_nxt_q   <= rcv_nxt_d;
            retry_q     <= retry_d;
            rto_q       <= rto_d;
            armed_q     <= armed_d;
            seg_valid_q <= seg_valid_d;
            seg_ctl_q   <= seg_ctl_d;
            seg_data_q  <= seg_data_d;
            stored_q    <= stored_d;
            pl_valid_q  <= pl_valid_d;
            pl_data_q   <= pl_data_d;
            err_q       <= err_d;
        end
    end

    // Outputs
    always_comb begin
        state           = state_q;
        conn_err        = err_q;
        bus.app_ready   = (state_q == S_ESTAB) && !seg_valid_q;
        bus.rx_ready    = !seg_valid_q;
        bus.seg_valid   = seg_valid_q;
        bus.seg_data    = seg_data_q;
        bus.rx_pl_valid = pl_valid_q;
        bus.rx_pl_data  = pl_data_q;
    end
endmodule
